// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and board defaults for the PLL lock supervisor
// Purpose: FSM state encoding, default cycle constants for the 27 MHz
//          reference clock, and the timer width helper.
// Ports:   none (package)
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } sup_state_t;

    // 27 MHz board defaults
    localparam int DEF_PLL_RST_CYCLES = 16;     // PLL reset pulse length
    localparam int DEF_LOCK_TIMEOUT   = 27000;  // 1 ms
    localparam int DEF_STABLE_CYCLES  = 2700;   // 100 us
    localparam int DEF_CNT_W          = 8;

    // One timer serves all three phases, so it is sized for the longest one.
    // Terminal compare is at N-1, so clog2(N) bits never wrap before it.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-stage synchronizer
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk  in          destination clock
//   rst  in          asynchronous active-high reset, clears both stages to 0
//   d    in  WIDTH   asynchronous input
//   q    out WIDTH   synchronized output, two clk edges behind d
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - rPLL reset sequencing and lock supervision
// Purpose: pulses the rPLL reset, waits for a stable lock, then releases the
//          core system reset; re-arms on lock loss and retries on timeout.
// Ports:
//   clk          in          27 MHz reference clock (same net as rPLL clkin)
//   reset        in          asynchronous active-high reset
//   pll_lock     in          rPLL LOCK, asynchronous to clk
//   soft_req     in          single-cycle request to restart the PLL sequence
//   pll_reset    out         to rPLL RESET, active-high
//   sys_reset    out         active-high core reset, low only in RUN
//   locked_ok    out         high only in RUN
//   state        out 2       current FSM state
//   loss_count   out CNT_W   lock losses seen in RUN, saturating
//   retry_count  out CNT_W   lock timeouts, saturating
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             soft_req,
    output logic             pll_reset,
    output logic             sys_reset,
    output logic             locked_ok,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count
);

    localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] ST_LAST  = TW'(STABLE_CYCLES - 1);

    sup_state_t    cur_state;
    logic [TW-1:0] timer;
    logic          lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign state = cur_state;

    // Outputs are assigned alongside each transition so they take their new
    // value on the same edge as the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= PLL_RST;
            timer       <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            locked_ok   <= 1'b0;
            loss_count  <= '0;
            retry_count <= '0;
        end else if (soft_req) begin
            // Restart overrides lock and timer events; counters untouched.
            cur_state <= PLL_RST;
            timer     <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            locked_ok <= 1'b0;
        end else begin
            case (cur_state)
                PLL_RST: begin
                    if (timer == RST_LAST) begin
                        cur_state <= WAIT_LOCK;
                        timer     <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        cur_state <= SETTLE;
                        timer     <= '0;
                    end else if (timer == TO_LAST) begin
                        cur_state <= PLL_RST;
                        timer     <= '0;
                        pll_reset <= 1'b1;
                        if (retry_count != '1)
                            retry_count <= retry_count + CNT_W'(1);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SETTLE: begin
                    // A dropout here is treated as a glitch, not a loss.
                    if (!lock_s) begin
                        cur_state <= WAIT_LOCK;
                        timer     <= '0;
                    end else if (timer == ST_LAST) begin
                        cur_state <= RUN;
                        timer     <= '0;
                        sys_reset <= 1'b0;
                        locked_ok <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RUN: begin
                    // Lock loss re-arms without resetting the PLL.
                    if (!lock_s) begin
                        cur_state <= WAIT_LOCK;
                        timer     <= '0;
                        sys_reset <= 1'b1;
                        locked_ok <= 1'b0;
                        if (loss_count != '1)
                            loss_count <= loss_count + CNT_W'(1);
                    end
                end
                default: begin
                    cur_state <= PLL_RST;
                    timer     <= '0;
                    pll_reset <= 1'b1;
                    sys_reset <= 1'b1;
                    locked_ok <= 1'b0;
                end
            endcase
        end
    end

endmodule
